// File: rtl/reg_write_history_if.sv
// Bundle of the commit/browse inputs and display outputs of reg_write_history.
// master drives the register-file write port and buttons; slave is the history buffer.
interface reg_write_history_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 8
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  logic              commit;
  logic              reg_write;
  logic [ADDR_W-1:0] reg_write_addr;
  logic [DATA_W-1:0] reg_write_data;
  logic              peek;
  logic [DATA_W-1:0] peek_data;
  logic              older;
  logic              newer;
  logic              clear;
  logic [DATA_W-1:0] out;
  logic [ADDR_W-1:0] out_addr;
  logic [CNT_W-1:0]  count;
  logic [IDX_W-1:0]  view_idx;
  logic              overflow;

  modport master (
    output commit, reg_write, reg_write_addr, reg_write_data,
    output peek, peek_data, older, newer, clear,
    input  out, out_addr, count, view_idx, overflow
  );

  modport slave (
    input  commit, reg_write, reg_write_addr, reg_write_data,
    input  peek, peek_data, older, newer, clear,
    output out, out_addr, count, view_idx, overflow
  );
endinterface

// File: rtl/reg_write_history.sv
// Circular history of the last DEPTH committed register writes, browsable for the debug display.
// Optional REG_HIST_DEDUP_EN: suppress a push identical to the current newest entry.
module reg_write_history #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  reg_write_history_if.slave    bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = ADDR_W + DATA_W;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [ENT_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [PTR_W-1:0]  r_view;
  logic              r_overflow;
  logic [DATA_W-1:0] r_out;
  logic [ADDR_W-1:0] r_out_addr;

  logic              w_push_req;
  logic              w_dup;
  logic              w_mem_we;
  logic [ENT_W-1:0]  w_wr_entry;
  logic [PTR_W-1:0]  w_wr_ptr_nxt;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [PTR_W-1:0]  w_view_nxt;
  logic              w_overflow_nxt;
  logic [PTR_W-1:0]  w_view_max;
  logic [PTR_W-1:0]  w_rd_idx;
  logic [ENT_W-1:0]  w_rd_entry;
  logic [DATA_W-1:0] w_out_nxt;
  logic [ADDR_W-1:0] w_out_addr_nxt;

  assign w_push_req = bus.commit && bus.reg_write;
  assign w_wr_entry = {bus.reg_write_addr, bus.reg_write_data};
  assign w_view_max = PTR_W'(r_count - CNT_W'(1));

`ifdef REG_HIST_DEDUP_EN
  logic [ENT_W-1:0] w_newest;
  assign w_newest = r_mem[r_wr_ptr - PTR_W'(1)];
  // count==0 covers clear-then-push: stale array contents never match
  assign w_dup    = (r_count != '0) && (w_newest == w_wr_entry);
`else
  assign w_dup    = 1'b0;
`endif

  always_comb begin
    w_mem_we       = 1'b0;
    w_wr_ptr_nxt   = r_wr_ptr;
    w_count_nxt    = r_count;
    w_view_nxt     = r_view;
    w_overflow_nxt = r_overflow;
    if (bus.clear) begin
      w_wr_ptr_nxt   = '0;
      w_count_nxt    = '0;
      w_view_nxt     = '0;
      w_overflow_nxt = 1'b0;
    end else if (w_push_req) begin
      w_view_nxt = '0;
      if (!w_dup) begin
        w_mem_we     = 1'b1;
        w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
        if (r_count == FULL) w_overflow_nxt = 1'b1;
        else                 w_count_nxt    = r_count + CNT_W'(1);
      end
    end else if ((bus.older != bus.newer) && (r_count != '0)) begin
      if (bus.older && (r_view != w_view_max)) w_view_nxt = r_view + PTR_W'(1);
      if (bus.newer && (r_view != '0))         w_view_nxt = r_view - PTR_W'(1);
    end
  end

  // Display is built from next-state so a push shows its own data on the capture edge
  assign w_rd_idx   = w_wr_ptr_nxt - PTR_W'(1) - w_view_nxt;
  assign w_rd_entry = r_mem[w_rd_idx];

  always_comb begin
    w_out_nxt      = '0;
    w_out_addr_nxt = '0;
    if (bus.peek) begin
      w_out_nxt = bus.peek_data;
    end else if (w_count_nxt == '0) begin
      w_out_nxt = '0;
    end else if (w_mem_we) begin
      w_out_nxt      = bus.reg_write_data;
      w_out_addr_nxt = bus.reg_write_addr;
    end else begin
      w_out_nxt      = w_rd_entry[DATA_W-1:0];
      w_out_addr_nxt = w_rd_entry[ENT_W-1:DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_wr_ptr] <= w_wr_entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_view     <= '0;
      r_overflow <= 1'b0;
      r_out      <= '0;
      r_out_addr <= '0;
    end else begin
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_count    <= w_count_nxt;
      r_view     <= w_view_nxt;
      r_overflow <= w_overflow_nxt;
      r_out      <= w_out_nxt;
      r_out_addr <= w_out_addr_nxt;
    end
  end

  assign bus.out      = r_out;
  assign bus.out_addr = r_out_addr;
  assign bus.count    = r_count;
  assign bus.view_idx = r_view;
  assign bus.overflow = r_overflow;
endmodule

// File: tb/tb_reg_write_history.sv
// Directed scoreboard bench for reg_write_history (DEPTH=8, 16-bit data, 3-bit address).
// Honors REG_HIST_DEDUP_EN for the duplicate-push expectation.
module tb_reg_write_history;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int D  = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  reg_write_history_if #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D)) bus ();

  reg_write_history #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          id;
    logic [15:0] o;
    logic [2:0]  a;
    logic [3:0]  c;
    logic [2:0]  v;
    logic        ov;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int total   = 0;
  int bad     = 0;
  int step_id = 0;

  function automatic void chk(string nm, int id, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s step%0d got=%0h want=%0h", nm, id, act, exp);
    end
  endfunction

  task automatic expect_st(input logic [15:0] o, input logic [2:0] a, input logic [3:0] c,
                           input logic [2:0] v, input logic ov);
    exp_t e;
    e.id = step_id; e.o = o; e.a = a; e.c = c; e.v = v; e.ov = ov;
    q.push_back(e);
    step_id++;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    bus.commit    = 1'b0;
    bus.reg_write = 1'b0;
    bus.older     = 1'b0;
    bus.newer     = 1'b0;
    bus.clear     = 1'b0;
  endtask

  task automatic push_in(input logic [2:0] a, input logic [15:0] d);
    bus.commit         = 1'b1;
    bus.reg_write      = 1'b1;
    bus.reg_write_addr = a;
    bus.reg_write_data = d;
  endtask

  task automatic check_zero(input int id);
    chk("rst_out",   id, int'(bus.out),      0);
    chk("rst_addr",  id, int'(bus.out_addr), 0);
    chk("rst_count", id, int'(bus.count),    0);
    chk("rst_view",  id, int'(bus.view_idx), 0);
    chk("rst_ovf",   id, int'(bus.overflow), 0);
  endtask

  // Monitor: outputs are sampled 1 time unit after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        chk("out",      mon_e.id, int'(bus.out),      int'(mon_e.o));
        chk("out_addr", mon_e.id, int'(bus.out_addr), int'(mon_e.a));
        chk("count",    mon_e.id, int'(bus.count),    int'(mon_e.c));
        chk("view_idx", mon_e.id, int'(bus.view_idx), int'(mon_e.v));
        chk("overflow", mon_e.id, int'(bus.overflow), int'(mon_e.ov));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    bus.commit = 0; bus.reg_write = 0; bus.reg_write_addr = 0; bus.reg_write_data = 0;
    bus.peek = 0; bus.peek_data = 0; bus.older = 0; bus.newer = 0; bus.clear = 0;
    #2;
    check_zero(-1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    push_in(3'd3, 16'h1234);          expect_st(16'h1234, 3'd3, 4'd1, 3'd0, 1'b0); tick();
    bus.clear = 1'b1;                 expect_st(16'h0000, 3'd0, 4'd0, 3'd0, 1'b0); tick();

    // fill past DEPTH: 8th push reaches full without overflow, 9th overwrites
    for (int i = 1; i <= 9; i++) begin
      push_in(3'(i), 16'(i));
      expect_st(16'(i), 3'(i), 4'((i > 8) ? 8 : i), 3'd0, (i == 9));
      tick();
    end
    for (int k = 1; k <= 7; k++) begin
      bus.older = 1'b1;
      expect_st(16'(9 - k), 3'(9 - k), 4'd8, 3'(k), 1'b1);
      tick();
    end
    bus.older = 1'b1;                 expect_st(16'h0002, 3'd2, 4'd8, 3'd7, 1'b1); tick();
    bus.older = 1'b1; bus.newer = 1'b1; expect_st(16'h0002, 3'd2, 4'd8, 3'd7, 1'b1); tick();
    bus.newer = 1'b1;                 expect_st(16'h0003, 3'd3, 4'd8, 3'd6, 1'b1); tick();

    bus.peek = 1'b1; bus.peek_data = 16'hBEEF;
    expect_st(16'hBEEF, 3'd0, 4'd8, 3'd6, 1'b1); tick();
    bus.peek_data = 16'hCAFE; bus.newer = 1'b1;
    expect_st(16'hCAFE, 3'd0, 4'd8, 3'd5, 1'b1); tick();
    bus.peek = 1'b0;
    expect_st(16'h0004, 3'd4, 4'd8, 3'd5, 1'b1); tick();

    bus.clear = 1'b1; push_in(3'd5, 16'h5555);
    expect_st(16'h0000, 3'd0, 4'd0, 3'd0, 1'b0); tick();
    bus.older = 1'b1;                 expect_st(16'h0000, 3'd0, 4'd0, 3'd0, 1'b0); tick();

    for (int i = 1; i <= 4; i++) begin
      push_in(3'(i), 16'(i * 16));
      expect_st(16'(i * 16), 3'(i), 4'(i), 3'd0, 1'b0);
      tick();
    end
    bus.older = 1'b1;                 expect_st(16'h0030, 3'd3, 4'd4, 3'd1, 1'b0); tick();
    bus.older = 1'b1;                 expect_st(16'h0020, 3'd2, 4'd4, 3'd2, 1'b0); tick();
    push_in(3'd6, 16'h0060); bus.older = 1'b1;
    expect_st(16'h0060, 3'd6, 4'd5, 3'd0, 1'b0); tick();
    bus.commit = 1'b1; bus.reg_write_addr = 3'd7; bus.reg_write_data = 16'hFFFF;
    expect_st(16'h0060, 3'd6, 4'd5, 3'd0, 1'b0); tick();
    bus.reg_write = 1'b1;
    expect_st(16'h0060, 3'd6, 4'd5, 3'd0, 1'b0); tick();

    bus.clear = 1'b1;                 expect_st(16'h0000, 3'd0, 4'd0, 3'd0, 1'b0); tick();
    push_in(3'd1, 16'h00AA);          expect_st(16'h00AA, 3'd1, 4'd1, 3'd0, 1'b0); tick();
    push_in(3'd1, 16'h00AA);
`ifdef REG_HIST_DEDUP_EN
    expect_st(16'h00AA, 3'd1, 4'd1, 3'd0, 1'b0);
`else
    expect_st(16'h00AA, 3'd1, 4'd2, 3'd0, 1'b0);
`endif
    tick();

    bus.clear = 1'b1;                 expect_st(16'h0000, 3'd0, 4'd0, 3'd0, 1'b0); tick();
    for (int i = 1; i <= 4; i++) begin
      push_in(3'(i), 16'(i * 256));
      expect_st(16'(i * 256), 3'(i), 4'(i), 3'd0, 1'b0);
      tick();
    end
    for (int k = 1; k <= 3; k++) begin
      bus.older = 1'b1;
      expect_st(16'(256 * (4 - k)), 3'(4 - k), 4'd4, 3'(k), 1'b0);
      tick();
    end

    // asynchronous reset between edges must clear outputs immediately
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_zero(-2);
    @(negedge clk);
    reset = 1'b0;
    push_in(3'd2, 16'h0777);          expect_st(16'h0777, 3'd2, 4'd1, 3'd0, 1'b0); tick();
    bus.older = 1'b1;                 expect_st(16'h0777, 3'd2, 4'd1, 3'd0, 1'b0); tick();

    tick();
    chk("drain", -3, q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reg_write_history.md
# reg_write_history

Register-file write-history buffer for the board debug display path: captures the last DEPTH committed register writes (destination address plus data) in a circular buffer. The front-panel buttons browse the buffer and drive a registered display value. A live-peek mode substitutes a second read-port value on the display. Sits between the register file write port / debounced button logic and the seven-segment/LED display mux.

## Interface
- DATA_W, 16, width of register data
- ADDR_W, 3, width of register address
- DEPTH, 8, history entries; power of two, 2..64

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clock clk
- commit  in  1  single-cycle pulse (button-release strobe); qualifies capture
- reg_write  in  1  register file write enable
- reg_write_addr  in  ADDR_W  destination register of current write
- reg_write_data  in  DATA_W  data of current write
- peek  in  1  level (debounced button); selects peek_data for display
- peek_data  in  DATA_W  register file second read-port data
- older  in  1  single-cycle pulse; browse toward older entry
- newer  in  1  single-cycle pulse; browse toward newer entry
- clear  in  1  single-cycle pulse; empties history
- out  out  DATA_W  registered display data
- out_addr  out  ADDR_W  registered address of displayed entry (0 in peek mode or when empty)
- count  out  $clog2(DEPTH+1)  valid entries, 0..DEPTH
- view_idx  out  $clog2(DEPTH)  displayed entry age, 0 = newest
- overflow  out  1  sticky: an entry has been overwritten since reset/clear

## Operation
- Storage: DEPTH x (ADDR_W+DATA_W) array, write pointer wr_ptr (mod DEPTH). Entry k (age k) lives at (wr_ptr-1-k) mod DEPTH.
- Push: commit && reg_write. Writes {reg_write_addr, reg_write_data} at wr_ptr, wr_ptr+1 mod DEPTH, count+1 saturating at DEPTH. Push while count==DEPTH overwrites oldest and sets overflow. Push forces view_idx to 0.
- Browse: older -> view_idx+1, saturating at count-1; newer -> view_idx-1, saturating at 0. Both asserted together: no change. count==0: view_idx stays 0.
- Clear: count=0, wr_ptr=0, view_idx=0, overflow=0. Array contents are not cleared (unobservable).
- Priority within one cycle: clear > push > browse. Browse pulses coincident with a push are dropped.
- Display: peek high -> out=peek_data, out_addr=0. Else count==0 -> out=0, out_addr=0. Else out/out_addr = entry view_idx.
- No FSM beyond the pointer/count/index state; all state in registers.

## Timing
- Reset: out=0, out_addr=0, count=0, view_idx=0, overflow=0, wr_ptr=0. Mid-operation reset discards all history immediately (async).
- out/out_addr are registered from next-state values. On the edge that performs a push, out loads reg_write_data in the same edge (zero extra latency, matches capture edge). Browse/clear/peek changes also appear after exactly one edge.
- peek_data is sampled every cycle while peek is high; out follows it with one-cycle latency.
- Push with count==DEPTH-1 -> count==DEPTH, overflow stays 0. Next push sets overflow on that edge.

## Configuration
- REG_HIST_DEDUP_EN defined: a push whose address and data both equal the current newest entry (count>0) is suppressed. wr_ptr/count/overflow are unchanged, but view_idx still forces to 0. A clear-then-push is never suppressed.
- Undefined: every qualified push is recorded, duplicates included.

## Test plan
- Reset, then commit+reg_write addr=3 data=0x1234 -> next edge out=0x1234, out_addr=3, count=1, view_idx=0, overflow=0.
- Push data 0x0001..0x0009 (DEPTH=8) -> count=8, overflow=1. Seven older pulses -> out=0x0002, view_idx=7. Further older -> unchanged.
- peek high, peek_data=0xBEEF -> out=0xBEEF, out_addr=0 next edge. peek low -> out returns to entry view_idx.
- Same cycle clear+commit+reg_write -> count=0, out=0. Same cycle commit+older with count=4, view_idx=2 -> view_idx=0, count=5.
- Assert reset mid-browse (view_idx=3) -> all outputs 0 without waiting for clk.
- With REG_HIST_DEDUP_EN: push addr=1 data=0x00AA twice -> count=1. Without it -> count=2.
